// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-port register file.
// Holds the FSM state encoding and the reset values for sp (x2) and gp (x3).
package cpu_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

    localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffc;
    localparam logic [31:0] GP_INIT_DEF = 32'h0000_1800;

    localparam int SP_IDX = 2;
    localparam int GP_IDX = 3;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard: issue sets a bit, writeback clears it, the init sweep clears one bit per cycle.
// busy reports the stored pending bit of each read address, with no same-cycle bypass.
module rf_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init,
    input  logic [AW-1:0]     i_init_idx,
    input  logic              i_iss_v,
    input  logic [AW-1:0]     i_iss_a,
    input  logic              i_wb0_v,
    input  logic [AW-1:0]     i_wb0_a,
    input  logic              i_wb1_v,
    input  logic [AW-1:0]     i_wb1_a,
    input  logic [NRD*AW-1:0] i_ra,
    output logic [NRD-1:0]    o_busy
);

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_next;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_sweep_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_dec
            assign w_set[gi]       = i_iss_v && (i_iss_a == AW'(gi));
            assign w_clr[gi]       = (i_wb0_v && (i_wb0_a == AW'(gi)))
                                  || (i_wb1_v && (i_wb1_a == AW'(gi)));
            assign w_sweep_hit[gi] = (i_init_idx == AW'(gi));
        end
    endgenerate

    // Set is applied after clear, so an issue colliding with a writeback leaves the bit set.
    always_comb begin
        w_pend_next = r_pend;
        if (i_init) begin
            w_pend_next = r_pend & ~w_sweep_hit;
        end else begin
            w_pend_next = (r_pend & ~w_clr) | w_set;
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_busy
            logic [AW-1:0] w_a;
            assign w_a        = i_ra[gi*AW +: AW];
            assign o_busy[gi] = !i_init && r_pend[w_a];
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with write-first bypass, a per-register pending
// scoreboard, and a post-reset sweep that loads x2/x3 and zeroes everything else.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter int              NREG    = 32,
    parameter int              NRD     = 2,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF),
    parameter logic [XLEN-1:0] GP_INIT = XLEN'(GP_INIT_DEF),
    localparam int             AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                we0,
    input  logic                we1,
    input  logic [AW-1:0]       wa0,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd0,
    input  logic [XLEN-1:0]     wd1,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      busy,
    input  logic                iss_v,
    input  logic [AW-1:0]       iss_a,
    input  logic [AW-1:0]       ra_dbg,
    output logic [XLEN-1:0]     rd_dbg
);

    rf_state_e       r_state;
    rf_state_e       w_state_next;
    logic [AW:0]     r_cnt;
    logic [AW:0]     w_cnt_next;
    logic [XLEN-1:0] r_mem [NREG];

    logic            w_init;
    logic [AW-1:0]   w_idx;
    logic [XLEN-1:0] w_init_val;
    logic            w_we0_eff;
    logic            w_we1_eff;
    logic            w_iss_eff;

    assign w_init    = (r_state == ST_INIT);
    assign w_idx     = r_cnt[AW-1:0];
    assign ready     = (r_state == ST_RUN);
    assign w_we0_eff = we0 && !w_init && (wa0 != '0);
    assign w_we1_eff = we1 && !w_init && (wa1 != '0);
    assign w_iss_eff = iss_v && !w_init && (iss_a != '0);

    always_comb begin
        w_init_val = '0;
        if (w_idx == AW'(SP_IDX)) begin
            w_init_val = SP_INIT;
        end else if (w_idx == AW'(GP_IDX)) begin
            w_init_val = GP_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The counter only advances in INIT, so once RUN is reached it parks and cannot wrap.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == (AW+1)'(NREG-1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_INIT;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Port 1 is written last so it wins when both ports target the same register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_init) begin
                r_mem[w_idx] <= w_init_val;
            end else begin
                if (w_we0_eff) begin
                    r_mem[wa0] <= wd0;
                end
                if (w_we1_eff) begin
                    r_mem[wa1] <= wd1;
                end
            end
        end
    end

    function automatic logic [XLEN-1:0] f_read(
        input logic [AW-1:0]   a,
        input logic [XLEN-1:0] stored,
        input logic            init,
        input logic            v0,
        input logic [AW-1:0]   a0,
        input logic [XLEN-1:0] d0,
        input logic            v1,
        input logic [AW-1:0]   a1,
        input logic [XLEN-1:0] d1
    );
        logic [XLEN-1:0] val;
        val = stored;
        if (init || (a == '0)) begin
            val = '0;
        end else if (v1 && (a1 == a)) begin
            val = d1;
        end else if (v0 && (a0 == a)) begin
            val = d0;
        end
        return val;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] w_a;
            assign w_a = ra[gi*AW +: AW];
            assign rd[gi*XLEN +: XLEN] = f_read(w_a, r_mem[w_a], w_init,
                                                w_we0_eff, wa0, wd0,
                                                w_we1_eff, wa1, wd1);
        end
    endgenerate

    assign rd_dbg = f_read(ra_dbg, r_mem[ra_dbg], w_init,
                           w_we0_eff, wa0, wd0, w_we1_eff, wa1, wd1);

    rf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_init     (w_init),
        .i_init_idx (w_idx),
        .i_iss_v    (w_iss_eff),
        .i_iss_a    (iss_a),
        .i_wb0_v    (w_we0_eff),
        .i_wb0_a    (wa0),
        .i_wb1_v    (w_we1_eff),
        .i_wb1_a    (wa1),
        .i_ra       (ra),
        .o_busy     (busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a register/pending-array model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                ready;
    logic                we0, we1;
    logic [AW-1:0]       wa0, wa1;
    logic [XLEN-1:0]     wd0, wd1;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      busy;
    logic                iss_v;
    logic [AW-1:0]       iss_a;
    logic [AW-1:0]       ra_dbg;
    logic [XLEN-1:0]     rd_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp dut (
        .clk    (clk),
        .rst    (rst),
        .ready  (ready),
        .we0    (we0),
        .we1    (we1),
        .wa0    (wa0),
        .wa1    (wa1),
        .wd0    (wd0),
        .wd1    (wd1),
        .ra     (ra),
        .rd     (rd),
        .busy   (busy),
        .iss_v  (iss_v),
        .iss_a  (iss_a),
        .ra_dbg (ra_dbg),
        .rd_dbg (rd_dbg)
    );

    always #5 clk = ~clk;

    // Model: register values, pending flags and number of sweep cycles remaining.
    logic [XLEN-1:0] m_reg [NREG];
    bit              m_pend [NREG];
    int              m_left  = 0;
    int              m_idx   = 0;
    bit              m_valid = 1'b0;

    function automatic logic [XLEN-1:0] init_val(input int idx);
        if (idx == 2) return 32'h0000_2ffc;
        if (idx == 3) return 32'h0000_1800;
        return 32'h0;
    endfunction

    function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a);
        if (m_left > 0 || a == 0) return 32'h0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return m_reg[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_left  <= NREG;
            m_idx   <= 0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (m_left > 0) begin
                m_reg[m_idx]  <= init_val(m_idx);
                m_pend[m_idx] <= 1'b0;
                m_idx         <= m_idx + 1;
                m_left        <= m_left - 1;
            end else begin
                if (we0 && wa0 != 0) begin
                    m_reg[wa0]  <= wd0;
                    m_pend[wa0] <= 1'b0;
                end
                if (we1 && wa1 != 0) begin
                    m_reg[wa1]  <= wd1;
                    m_pend[wa1] <= 1'b0;
                end
                if (iss_v && iss_a != 0) m_pend[iss_a] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [XLEN-1:0] exp_d;
            logic            exp_b;
            n_tests++;
            if (ready !== (m_left == 0)) begin
                n_fail++;
                $display("FAIL model_ready t=%0t act=%b exp=%b", $time, ready, (m_left == 0));
            end
            for (int k = 0; k < NRD; k++) begin
                exp_d = model_read(ra[k*AW +: AW]);
                exp_b = (m_left > 0) ? 1'b0 : m_pend[ra[k*AW +: AW]];
                n_tests++;
                if (rd[k*XLEN +: XLEN] !== exp_d) begin
                    n_fail++;
                    $display("FAIL model_rd%0d t=%0t act=%h exp=%h", k, $time, rd[k*XLEN +: XLEN], exp_d);
                end
                n_tests++;
                if (busy[k] !== exp_b) begin
                    n_fail++;
                    $display("FAIL model_busy%0d t=%0t act=%b exp=%b", k, $time, busy[k], exp_b);
                end
            end
            exp_d = model_read(ra_dbg);
            n_tests++;
            if (rd_dbg !== exp_d) begin
                n_fail++;
                $display("FAIL model_dbg t=%0t act=%h exp=%h", $time, rd_dbg, exp_d);
            end
        end
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; we1 = 1'b0; iss_v = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_a = '0;
    endtask

    initial begin
        int cyc;
        idle_inputs();
        ra     = '0;
        ra_dbg = '0;
        rst    = 1'b1;

        // Reset and sweep: ready rises after exactly NREG cycles.
        tick();
        rst = 1'b0;
        chk("ready_after_rst", {31'b0, ready}, 32'h0);
        wait_ready(cyc);
        chk("ready_cycle", cyc, 32);

        ra_dbg = 5'd2; #1; chk("dbg_x2", rd_dbg, 32'h0000_2ffc);
        ra_dbg = 5'd3; #1; chk("dbg_x3", rd_dbg, 32'h0000_1800);
        ra_dbg = 5'd5; #1; chk("dbg_x5", rd_dbg, 32'h0);

        // Same-cycle bypass on port 0, then stored value.
        tick();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hAAAA_0001; ra = {5'd0, 5'd5};
        #1; chk("bypass_rd0_x5", rd[31:0], 32'hAAAA_0001);
        tick();
        idle_inputs();
        #1; chk("stored_rd0_x5", rd[31:0], 32'hAAAA_0001);

        // Dual write to x7: port 1 wins.
        tick();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'd1;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'd2;
        ra = {5'd7, 5'd0};
        #1; chk("dual_bypass_x7", rd[63:32], 32'd2);
        tick();
        idle_inputs();
        #1; chk("dual_stored_x7", rd[63:32], 32'd2);

        // x0 is hardwired: write and issue to x0 have no effect.
        tick();
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
        iss_v = 1'b1; iss_a = 5'd0; ra = {5'd0, 5'd0}; ra_dbg = 5'd0;
        #1; chk("x0_bypass", rd[31:0], 32'h0);
        tick();
        idle_inputs();
        #1; chk("x0_stored", rd[63:32], 32'h0);
        chk("x0_busy", {30'b0, busy}, 32'h0);
        chk("x0_dbg", rd_dbg, 32'h0);

        // Scoreboard on x9.
        tick();
        iss_v = 1'b1; iss_a = 5'd9; ra = {5'd0, 5'd9};
        #1; chk("busy_x9_same_cycle", {31'b0, busy[0]}, 32'h0);
        tick();
        idle_inputs();
        #1; chk("busy_x9_after_issue", {31'b0, busy[0]}, 32'h1);
        tick();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1234_5678; iss_v = 1'b1; iss_a = 5'd9;
        tick();
        idle_inputs();
        #1; chk("busy_x9_issue_wins", {31'b0, busy[0]}, 32'h1);
        tick();
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0BAD_F00D;
        tick();
        idle_inputs();
        #1; chk("busy_x9_cleared", {31'b0, busy[0]}, 32'h0);
        chk("x9_value", rd[31:0], 32'h0BAD_F00D);

        // Reset pulsed mid-sweep (index 10), with writes/issues held during INIT.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0000_1234;
        iss_v = 1'b1; iss_a = 5'd9;
        wait_ready(cyc);
        idle_inputs();
        chk("ready_cycle_midinit", cyc, 32);
        ra = {5'd0, 5'd9};
        ra_dbg = 5'd5; #1; chk("init_write_discarded_x5", rd_dbg, 32'h0);
        chk("init_issue_discarded_x9", {31'b0, busy[0]}, 32'h0);
        ra_dbg = 5'd2; #1; chk("dbg_x2_resweep", rd_dbg, 32'h0000_2ffc);

        // Reset pulsed in RUN.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ready_low_after_run_rst", {31'b0, ready}, 32'h0);
        wait_ready(cyc);
        chk("ready_cycle_run_rst", cyc, 32);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of 2, >=4); AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter SP_INIT, default 32'h2ffc, init value of register 2.
REQ-005 SHALL have parameter GP_INIT, default 32'h1800, init value of register 3.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port ready  output  1  high when init sweep is done and the file is usable.
REQ-009 SHALL have ports we0/we1  input  1 each  write enables; port 1 is the higher-priority writer.
REQ-010 SHALL have ports wa0/wa1  input  AW each  write addresses.
REQ-011 SHALL have ports wd0/wd1  input  XLEN each  write data.
REQ-012 SHALL have port ra  input  NRD*AW  packed read addresses; port k is bits [k*AW +: AW].
REQ-013 SHALL have port rd  output  NRD*XLEN  packed read data, same packing as ra.
REQ-014 SHALL have port busy  output  NRD  scoreboard pending bit for each read address.
REQ-015 SHALL have ports iss_v/iss_a  input  1/AW  issue handshake: marks destination iss_a pending.
REQ-016 SHALL have ports ra_dbg/rd_dbg  input AW / output XLEN  debug read port.

Function
REQ-017 SHALL read all ports combinationally; register 0 always reads 0 and is never written or marked pending.
REQ-018 SHALL give write-first bypass on each read port and on debug: if we1 and wa1==ra (nonzero), return wd1; else if we0 and wa0==ra, return wd0; else return stored value.
REQ-019 SHALL commit writes on the rising clk edge; if we0 and we1 target the same address, wd1 is stored.
REQ-020 SHALL use FSM states INIT and RUN; rst forces INIT with sweep counter 0.
REQ-021 In INIT, SHALL write one register per cycle (index = counter: 2->SP_INIT, 3->GP_INIT, else 0), clear its pending bit, and increment the counter.
REQ-022 SHALL go to RUN on the cycle after index NREG-1 is written; INIT lasts exactly NREG cycles; ready=1 only in RUN.
REQ-023 In INIT, SHALL ignore we0/we1/iss_v, force rd/rd_dbg to 0 and busy to 0.
REQ-024 In RUN, iss_v with nonzero iss_a SHALL set pending[iss_a] at the next edge.
REQ-025 In RUN, a write on port 0 or port 1 SHALL clear pending[wa] at the next edge.
REQ-026 When issue and writeback hit the same register in one cycle, pending SHALL end set (issue wins).
REQ-027 busy[k] SHALL equal pending[ra_k] with no bypass of same-cycle writeback or issue.
REQ-028 The sweep counter SHALL be AW+1 bits wide and SHALL NOT wrap back to INIT without rst.

Reset
REQ-029 On rst asserted at a clock edge, SHALL set ready=0 and state=INIT on the next cycle, including in the middle of RUN or of INIT, where the sweep restarts at index 0.
REQ-030 Register contents SHALL be defined only by the sweep; no initial blocks are relied on.

Structure
REQ-031 SHALL define the FSM state enum and the default init constants (SP_INIT, GP_INIT) in a shared package, cpu_pkg.
REQ-032 SHALL use one sub-module, rf_scoreboard, holding the pending bits and the issue/writeback logic; storage and bypass stay in the top level.

Verification
REQ-033 Reset then 32 idle cycles -> ready rises at cycle 32 (not 31); debug reads give x2=32'h2ffc, x3=32'h1800, x5=0.
REQ-034 we0 wa0=5 wd0=32'hAAAA_0001 with ra port0=5 in the same cycle -> rd port0=32'hAAAA_0001 combinationally, and the stored value is visible next cycle.
REQ-035 we0 and we1 both to x7 (wd0=1, wd1=2) -> same-cycle read returns 2, and x7=2 afterwards.
REQ-036 write 32'hFFFF_FFFF to x0 -> all reads of x0 return 0, and busy is never set.
REQ-037 iss_v x9 -> busy=1 next cycle; writeback to x9 together with iss_v x9 -> busy stays 1; a later writeback alone clears it.
REQ-038 rst pulsed at sweep index 10, then re-pulsed in RUN -> ready low for exactly NREG cycles after each pulse; writes during INIT are discarded.
